// File: rtl/abc_fetch_pkg.sv
// abc_fetch_pkg: shared types and defaults for the instruction fetch slice.
// Holds the fetch FSM state enum plus default widths and reset address.
package abc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

  localparam int unsigned ICWIDTH_DEF    = 8;
  localparam int unsigned IWWIDTH_DEF    = 58;
  localparam int unsigned RESET_ADDR_DEF = 0;

endpackage

// File: rtl/abc_fetch_slot.sv
// abc_fetch_slot: one instruction + PC holding register with a valid flag.
// Ports: clk_i, rst_i; load_i (wins over clr_i), clr_i; instr_i/pc_i in;
// valid_o, instr_o, pc_o out. Clearing drops valid only.
module abc_fetch_slot
  import abc_fetch_pkg::*;
#(
  parameter int unsigned AW = ICWIDTH_DEF,
  parameter int unsigned DW = IWWIDTH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          clr_i,
  input  logic [DW-1:0] instr_i,
  input  logic [AW-1:0] pc_i,
  output logic          valid_o,
  output logic [DW-1:0] instr_o,
  output logic [AW-1:0] pc_o
);

  logic          valid_q;
  logic [DW-1:0] instr_q;
  logic [AW-1:0] pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/abc_instr_fetch.sv
// abc_instr_fetch: PC owner and NVM fetch sequencer feeding decode via
// valid/ready. Ports: CLK, RST (async high), RUN; NVM_START/NVM_ADDRESS out,
// NVM_STALL/NVM_INSTRUCTION in; INSTR_VALID/INSTR/INSTR_PC out, INSTR_READY,
// JUMP, JUMP_ADDR in. Define ABC_FETCH_PREFETCH_EN for a speculative slot.
module abc_instr_fetch
  import abc_fetch_pkg::*;
#(
  parameter int unsigned ICWIDTH    = ICWIDTH_DEF,
  parameter int unsigned IWWIDTH    = IWWIDTH_DEF,
  parameter int unsigned RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RUN,
  output logic               NVM_START,
  output logic [ICWIDTH-1:0] NVM_ADDRESS,
  input  logic               NVM_STALL,
  input  logic [IWWIDTH-1:0] NVM_INSTRUCTION,
  output logic               INSTR_VALID,
  input  logic               INSTR_READY,
  output logic [IWWIDTH-1:0] INSTR,
  output logic [ICWIDTH-1:0] INSTR_PC,
  input  logic               JUMP,
  input  logic [ICWIDTH-1:0] JUMP_ADDR
);

  typedef logic [ICWIDTH-1:0] pc_t;
  localparam pc_t RST_PC = pc_t'(RESET_ADDR);

  fetch_state_e state_q, state_d;
  pc_t          pc_q, pc_d;
  pc_t          addr_q, addr_d;
  logic         hs, cap;

  logic               s0_valid, s0_load, s0_clr;
  logic [IWWIDTH-1:0] s0_instr, s0_din;
  pc_t                s0_pc, s0_pin;

  assign hs  = s0_valid & INSTR_READY;
  assign cap = (state_q == WAIT) & ~NVM_STALL;

  assign NVM_START   = (state_q == REQ);
  assign NVM_ADDRESS = addr_q;
  assign INSTR_VALID = s0_valid;
  assign INSTR       = s0_instr;
  assign INSTR_PC    = s0_pc;

  abc_fetch_slot #(.AW(ICWIDTH), .DW(IWWIDTH)) u_slot0 (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (s0_load),
    .clr_i   (s0_clr),
    .instr_i (s0_din),
    .pc_i    (s0_pin),
    .valid_o (s0_valid),
    .instr_o (s0_instr),
    .pc_o    (s0_pc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
      addr_q  <= RST_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

`ifdef ABC_FETCH_PREFETCH_EN

  // pc_q is the next sequential address to request; drop_q marks an
  // outstanding speculative fetch made stale by a taken jump.
  logic               s1_valid, s1_load, s1_clr;
  logic [IWWIDTH-1:0] s1_instr;
  pc_t                s1_pc;
  logic               drop_q, drop_d;
  logic               redirect, keep, busy_nx, v0_nx, v1_nx;
  pc_t                base_pc;

  abc_fetch_slot #(.AW(ICWIDTH), .DW(IWWIDTH)) u_slot1 (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (s1_load),
    .clr_i   (s1_clr),
    .instr_i (NVM_INSTRUCTION),
    .pc_i    (addr_q),
    .valid_o (s1_valid),
    .instr_o (s1_instr),
    .pc_o    (s1_pc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) drop_q <= 1'b0;
    else     drop_q <= drop_d;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    drop_d   = drop_q;
    s0_din   = NVM_INSTRUCTION;
    s0_pin   = addr_q;
    s0_load  = 1'b0;
    redirect = hs & JUMP;
    keep     = cap & ~drop_q & ~redirect;
    base_pc  = redirect ? JUMP_ADDR : pc_q;
    pc_d     = base_pc;
    s0_clr   = hs;
    s1_clr   = hs;
    s1_load  = keep & s0_valid & ~hs;
    if (hs & s1_valid & ~JUMP) begin
      s0_load = 1'b1;
      s0_din  = s1_instr;
      s0_pin  = s1_pc;
    end else if (keep & (~s0_valid | hs)) begin
      s0_load = 1'b1;
    end
    v0_nx   = s0_load | (s0_valid & ~s0_clr);
    v1_nx   = s1_load | (s1_valid & ~s1_clr);
    busy_nx = (state_q == REQ) | ((state_q == WAIT) & NVM_STALL);
    if (busy_nx) begin
      state_d = WAIT;
      drop_d  = drop_q | redirect;
    end else begin
      drop_d = 1'b0;
      if (RUN & ~(v0_nx & v1_nx)) begin
        state_d = REQ;
        addr_d  = base_pc;
        pc_d    = base_pc + pc_t'(1);
      end else if (v0_nx | v1_nx) begin
        state_d = HOLD;
      end else begin
        state_d = IDLE;
      end
    end
  end

`else

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    s0_load = 1'b0;
    s0_clr  = 1'b0;
    s0_din  = NVM_INSTRUCTION;
    s0_pin  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (RUN) begin
          state_d = REQ;
          addr_d  = pc_q;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (cap) begin
          state_d = HOLD;
          s0_load = 1'b1;
        end
      end
      HOLD: begin
        if (hs) begin
          s0_clr = 1'b1;
          pc_d   = JUMP ? JUMP_ADDR : s0_pc + pc_t'(1);
          if (RUN) begin
            state_d = REQ;
            addr_d  = pc_d;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`endif

endmodule

// File: tb/tb_abc_instr_fetch.sv
// tb_abc_instr_fetch: scoreboard bench with an NVM model and a program-order
// reference model (next PC = jump ? target : pc+1, wrapping at 8 bits).
module tb_abc_instr_fetch;
  localparam int AW = 8;
  localparam int DW = 58;
`ifdef ABC_FETCH_PREFETCH_EN
  localparam int PER = 2;
`else
  localparam int PER = 3;
`endif

  logic clk = 1'b0;
  logic rst, run, stall, start, valid, ready, jump;
  logic [AW-1:0] addr, ipc, jaddr;
  logic [DW-1:0] nvm_d, instr;
  logic [DW-1:0] mem [256];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int stall_def = 0;
  int stall_addr = -1;
  int stall_fix = 4;
  int st_c[$];
  logic [AW-1:0] st_a[$];
  int vr_c[$];
  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  abc_instr_fetch dut (
    .CLK(clk), .RST(rst), .RUN(run),
    .NVM_START(start), .NVM_ADDRESS(addr),
    .NVM_STALL(stall), .NVM_INSTRUCTION(nvm_d),
    .INSTR_VALID(valid), .INSTR_READY(ready),
    .INSTR(instr), .INSTR_PC(ipc),
    .JUMP(jump), .JUMP_ADDR(jaddr)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // NVM model: latches address on START, stalls, then returns mem[addr]
  int rem;
  logic busy = 1'b0;
  logic was;
  logic [AW-1:0] na;
  initial begin
    stall = 1'b0;
    nvm_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
        stall = 1'($urandom);
      end else begin
        was = busy;
        if (busy) begin
          chk("addr_stable", addr, na);
          chk("no_start_busy", start, 0);
          if (rem > 0) begin
            rem--;
            stall = 1'b1;
            nvm_d = DW'({$urandom(), $urandom()});
          end else begin
            stall = 1'b0;
            nvm_d = mem[na];
            busy = 1'b0;
          end
        end
        if (start && !was) begin
          na = addr;
          busy = 1'b1;
          if (int'(addr) == stall_addr) rem = stall_fix;
          else if (stall_def < 0) rem = int'($urandom_range(0, 3));
          else rem = stall_def;
          stall = 1'($urandom);
          nvm_d = DW'({$urandom(), $urandom()});
        end else if (!was) begin
          stall = 1'($urandom);
          nvm_d = DW'({$urandom(), $urandom()});
        end
      end
    end
  end

  // Monitor / scoreboard
  logic pv = 1'b0, phs = 1'b0, pst = 1'b0;
  logic [DW-1:0] pins;
  logic [AW-1:0] ppc, e, nx;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; phs = 1'b0; pst = 1'b0;
      end else begin
        if (start) begin
          st_c.push_back(cyc);
          st_a.push_back(addr);
        end
        if (valid && (!pv || phs)) vr_c.push_back(cyc);
        if (pst) begin
          chk("hold_valid", valid, 1);
          chk("hold_instr", instr, pins);
          chk("hold_pc", ipc, ppc);
        end
        if (valid && ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", ipc, e);
            chk("sb_instr", instr, mem[e]);
            nx = jump ? jaddr : e + 8'd1;
            exp_q.push_back(nx);
          end
        end
        pv = valid;
        phs = valid && ready;
        pst = valid && !ready;
        pins = instr;
        ppc = ipc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    st_c.delete();
    st_a.delete();
    vr_c.delete();
  endtask

  task automatic get_start(output int c, output logic [AW-1:0] a);
    c = -1;
    a = '0;
    for (int i = 0; i < 200; i++) begin
      if (st_c.size() > 0) begin
        c = st_c.pop_front();
        a = st_a.pop_front();
        return;
      end
      tick();
    end
    chk("start_timeout", 0, 1);
  endtask

  task automatic seek_start(input logic [AW-1:0] t, output int c);
    logic [AW-1:0] a;
    c = -1;
    for (int i = 0; i < 12; i++) begin
      get_start(c, a);
      if (a == t) return;
    end
    chk("seek_start", a, t);
  endtask

  task automatic get_vr_after(input int t, output int v);
    v = -1;
    for (int i = 0; i < 200; i++) begin
      while (vr_c.size() > 0) begin
        v = vr_c.pop_front();
        if (v > t) return;
      end
      tick();
    end
    chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_hs();
    int n0;
    n0 = hs_cnt;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (hs_cnt != n0) return;
    end
    chk("hs_timeout", 0, 1);
  endtask

  int c, c1, c2, v, t0;
  logic [AW-1:0] a, a1, a2, spc;
  logic [DW-1:0] sins;
  bit got;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'({$urandom(), $urandom()});
    rst = 1'b1; run = 1'b0; ready = 1'b1; jump = 1'b0; jaddr = '0;
    exp_q.push_back(8'h00);
    repeat (3) tick();
    chk("rst_start", start, 0);
    chk("rst_addr", addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", ipc, 0);
    rst = 1'b0;
    #1 chk("rel_no_start", start, 0);

    // zero-stall streaming
    tick();
    flush();
    run = 1'b1;
    t0 = cyc;
    get_start(c, a);
    chk("run_to_start", c, t0 + 1);
    chk("start_a0", a, 0);
    get_start(c1, a1);
    chk("start_a1", a1, 1);
    chk("spacing1", c1 - c, PER);
    get_start(c2, a2);
    chk("start_a2", a2, 2);
    chk("spacing2", c2 - c1, PER);
    get_vr_after(c - 1, v);
    chk("valid_lat", v, c + 2);

    // long stall at a jump target
    stall_addr = 8'h25;
    jaddr = 8'h25;
    jump = 1'b1;
    wait_hs();
    jump = 1'b0;
    seek_start(8'h25, c);
    get_vr_after(c, v);
    chk("stall_valid", v, c + 6);
    stall_addr = -1;

    // consumer backpressure, then jump to 0x40
    ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = valid;
    end
    chk("hold_seen", got, 1);
    sins = instr;
    spc = ipc;
    jump = 1'b1;
    jaddr = 8'h33;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_instr", instr, sins);
      chk("bp_pc", ipc, spc);
`ifndef ABC_FETCH_PREFETCH_EN
      chk("bp_no_start", start, 0);
`endif
    end
    flush();
    jaddr = 8'h40;
    ready = 1'b1;
    wait_hs();
    jump = 1'b0;
    get_start(c, a);
    chk("jump_40", a, 8'h40);

    // wrap 0xFF -> 0x00
    jaddr = 8'hFF;
    jump = 1'b1;
    wait_hs();
    jump = 1'b0;
    seek_start(8'hFF, c);
    get_start(c, a);
    chk("wrap", a, 8'h00);

    // reset during WAIT
    stall_def = 5;
    flush();
    get_start(c, a);
    while (cyc < c + 2) tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", valid, 0);
    chk("midrst_start", start, 0);
    chk("midrst_addr", addr, 0);
    exp_q.delete();
    exp_q.push_back(8'h00);
    stall_def = 0;
    tick();
    tick();
    rst = 1'b0;
    t0 = cyc;
    #1 chk("rel2_no_start", start, 0);
    flush();
    get_start(c, a);
    chk("rel2_addr", a, 0);
    chk("rel2_lat", c, t0 + 1);

    // randomized traffic
    stall_def = -1;
    for (int i = 0; i < 2500; i++) begin
      tick();
      ready = ($urandom_range(0, 3) != 0);
      jump = ($urandom_range(0, 7) == 0);
      jaddr = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 49) == 0) run = ~run;
    end
    run = 1'b1;
    ready = 1'b1;
    jump = 1'b0;
    repeat (20) tick();
    chk("progress", hs_cnt > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/abc_instr_fetch.md
# abc_instr_fetch

Instruction fetch sequencer for the CoreABC-style controller, sitting directly upstream of the instruction NVM block. It owns the program counter, drives the NVM fetch handshake (start pulse, address, stall), captures the returned instruction word and presents it to the decode/execute stage through a valid/ready interface. It redirects the program counter when the consumer reports a taken jump.

## Interface
- ICWIDTH, 8, program counter / NVM address width; PC wraps modulo 2^ICWIDTH
- IWWIDTH, 58, instruction word width
- RESET_ADDR, 0, PC value after reset
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  one clock; reset is asynchronous and active-high
- RUN  in  1  fetch enable; level-sensitive
- NVM_START  out  1  one-cycle fetch request pulse to NVM
- NVM_ADDRESS  out  ICWIDTH  fetch address; stable from START until capture
- NVM_STALL  in  1  NVM busy; data not yet valid
- NVM_INSTRUCTION  in  IWWIDTH  instruction word from NVM
- INSTR_VALID  out  1  INSTR/INSTR_PC hold a valid fetched instruction
- INSTR_READY  in  1  consumer accepts instruction this cycle
- INSTR  out  IWWIDTH  fetched instruction
- INSTR_PC  out  ICWIDTH  address INSTR was fetched from
- JUMP  in  1  qualifier: accepted instruction is a taken jump
- JUMP_ADDR  in  ICWIDTH  jump target

## Operation
- Reset values: NVM_START=0, NVM_ADDRESS=RESET_ADDR, INSTR_VALID=0, INSTR=0, INSTR_PC=0; internal PC=RESET_ADDR; FSM=IDLE.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: RUN=1 -> REQ.
  - REQ: NVM_START=1 for exactly this cycle, NVM_ADDRESS=PC -> WAIT.
  - WAIT: NVM_STALL=0 -> capture NVM_INSTRUCTION into INSTR, PC into INSTR_PC, set INSTR_VALID -> HOLD. NVM_STALL=1 -> stay.
  - HOLD: INSTR_VALID=1; on INSTR_VALID&INSTR_READY: PC <= JUMP ? JUMP_ADDR : INSTR_PC+1; INSTR_VALID clears; -> REQ if RUN else IDLE. No handshake -> stay, outputs stable.
- JUMP/JUMP_ADDR sampled only in a handshake cycle; ignored otherwise.
- PC increment wraps: 2^ICWIDTH-1 -> 0.
- RUN deasserted during REQ/WAIT: outstanding fetch completes and is presented normally; no new START issued after the handshake.
- NVM_ADDRESS changes only when entering REQ; never while a fetch is outstanding.
- Reset mid-fetch: outstanding NVM access abandoned, all state to reset values; no START in the first cycle after reset release.

## Timing
- RUN rising in IDLE at cycle t -> NVM_START at t+1.
- START at cycle t; NVM_STALL sampled from t+1; capture on first edge at or after end of t+1 with NVM_STALL=0. Zero-stall: INSTR_VALID at t+2.
- Zero-stall, INSTR_READY held high, no prefetch: one instruction every 3 cycles.
- Handshake at cycle h -> next NVM_START at h+1 (target address already on NVM_ADDRESS at h+1).

## Configuration
- ABC_FETCH_PREFETCH_EN defined: second instruction slot; in HOLD, fetch of INSTR_PC+1 issued immediately (speculative). On handshake without JUMP, prefetched word moves to INSTR in the same edge it is captured or the edge after, giving one instruction every 2 cycles with zero-stall NVM. On handshake with JUMP: prefetched word discarded (outstanding NVM access runs to completion and is dropped), then REQ for JUMP_ADDR. At most one speculative fetch outstanding.
- Undefined: single slot, behaviour exactly as in Operation.

## Structure
- Package abc_fetch_pkg: FSM state enum (IDLE, REQ, WAIT, HOLD), default widths, RESET_ADDR default constant.
- Sub-module abc_fetch_slot: instruction+PC holding register with valid flag, load/clear controls; instantiated once, twice with ABC_FETCH_PREFETCH_EN.

## Test plan
- Reset then RUN=1, NVM zero-stall, READY=1 -> START at addresses 0,1,2 spaced 3 cycles; INSTR_PC 0,1,2 with matching words.
- NVM_STALL high 4 cycles after START at address 5 -> NVM_ADDRESS held at 5, INSTR_VALID rises one cycle after STALL falls, no second START.
- READY=0 for 6 cycles in HOLD -> INSTR/INSTR_PC stable, no START; READY=1 with JUMP=1, JUMP_ADDR=0x40 -> next START addresses 0x40.
- PC=0xFF accepted without jump -> next fetch address 0x00.
- RST asserted during WAIT -> INSTR_VALID=0, NVM_START=0 immediately; after release, RUN=1 fetches RESET_ADDR.
- With ABC_FETCH_PREFETCH_EN, zero-stall: throughput 2 cycles/instr; JUMP to 0x10 at address 3 -> prefetched word for 4 never appears on INSTR, next INSTR_PC=0x10.
